// File: rtl/rv_burst_tx.sv
// rtl/rv_burst_tx.sv - valid/ready stream burst transmitter
module rv_burst_tx #(
   parameter int DW    = 8,
   parameter int LEN_W = 8,
   parameter int GAP_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [DW-1:0]    base_i,
   input  logic [GAP_W-1:0] gap_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [LEN_W-1:0] beat_cnt_o,
   output logic [DW-1:0]    data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [DW-1:0]    data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Next-state and registered-output logic; every output comes from a flop.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      gap_d      = gap_q;
      gap_cnt_d  = gap_cnt_q;
      beat_cnt_d = beat_cnt_q;
      data_d     = data_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               beat_cnt_d = '0;
               busy_d     = 1'b1;
               if (len_i != '0) begin
                  len_d   = len_i;
                  gap_d   = gap_i;
                  data_d  = base_i;
                  valid_d = 1'b1;
                  state_d = S_SEND;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_SEND: begin
            // Data and valid stay frozen until the downstream takes the beat.
            if (valid_q && ready_i) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               data_d     = data_q + 1'b1;
               if (beat_cnt_q + 1'b1 == len_q) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else if (gap_q != '0) begin
                  valid_d   = 1'b0;
                  gap_cnt_d = gap_q;
                  state_d   = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Down-counter: the last idle cycle is the one where the count reads 1.
            if (gap_cnt_q <= 1) begin
               valid_d = 1'b1;
               state_d = S_SEND;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; reset abandons any burst and clears valid immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         gap_q      <= '0;
         gap_cnt_q  <= '0;
         beat_cnt_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         gap_q      <= gap_d;
         gap_cnt_q  <= gap_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign beat_cnt_o = beat_cnt_q;
   assign data_o     = data_q;
   assign valid_o    = valid_q;

endmodule

// File: tb/tb_rv_burst_tx.sv
// tb/tb_rv_burst_tx.sv - self-checking bench for rv_burst_tx
module tb_rv_burst_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i;
   logic [7:0] len_i;
   logic [7:0] base_i;
   logic [3:0] gap_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] beat_cnt_o;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;

   int n_checks = 0;
   int n_fails  = 0;

   rv_burst_tx #(.DW(8), .LEN_W(8), .GAP_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .len_i      (len_i),
      .base_i     (base_i),
      .gap_i      (gap_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .beat_cnt_o (beat_cnt_o),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   // Runs one burst: the expected beat list is built up front, and the stream is
   // checked against it cycle by cycle. stall forces ready_i low for the first cycles.
   task automatic run_burst(input int len, input logic [7:0] base, input int gap,
                            input int ready_pct, input int stall);
      logic [7:0] exp_q[$];
      int         cycles, budget, zeros, beat;
      bit         pend, held;
      logic [7:0] held_data;
      for (int i = 0; i < len; i++) exp_q.push_back(8'(base + i));
      budget = 64 + len * (gap + 1) * 20 + stall;
      start_i = 1'b1;
      len_i   = 8'(len);
      base_i  = base;
      gap_i   = 4'(gap);
      tick();
      start_i = 1'b0;
      len_i   = 8'($urandom_range(1, 255));
      base_i  = 8'($urandom);
      gap_i   = 4'($urandom);
      if (len == 0) begin
         chk("zero_len_done", done_o, 1);
         chk("zero_len_valid", valid_o, 0);
         chk("zero_len_busy", busy_o, 1);
         tick();
         chk("zero_len_done_end", done_o, 0);
         chk("zero_len_idle", busy_o, 0);
         chk("zero_len_no_valid", valid_o, 0);
         return;
      end
      chk("first_valid", valid_o, 1);
      chk("first_data", data_o, base);
      chk("first_busy", busy_o, 1);
      chk("first_cnt", beat_cnt_o, 0);
      cycles = 0; zeros = 0; beat = 0; pend = 0; held = 0; held_data = '0;
      while (exp_q.size() > 0 && cycles < budget) begin
         ready_i = (cycles < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
         start_i = ($urandom_range(7) == 0);
         if (!valid_o) begin
            if (pend) zeros++;
            else chk("valid_retract", valid_o, 1);
         end else begin
            if (pend) begin
               chk("gap_len", zeros, gap);
               pend = 0;
            end
            if (held) chk("hold_data", data_o, held_data);
         end
         if (done_o) chk("early_done", done_o, 0);
         held      = valid_o && !ready_i;
         held_data = data_o;
         if (valid_o && ready_i) begin
            chk("beat_data", data_o, exp_q.pop_front());
            chk("beat_cnt", beat_cnt_o, beat);
            beat++;
            pend  = (exp_q.size() > 0);
            zeros = 0;
         end
         tick();
         cycles++;
      end
      start_i = 1'b0;
      ready_i = 1'b0;
      if (exp_q.size() > 0) begin
         chk("burst_timeout", exp_q.size(), 0);
         do_reset();
         return;
      end
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 1);
      chk("done_valid", valid_o, 0);
      chk("final_cnt", beat_cnt_o, len);
      tick();
      chk("done_end", done_o, 0);
      chk("idle_busy", busy_o, 0);
      chk("idle_valid", valid_o, 0);
      chk("hold_cnt", beat_cnt_o, len);
   endtask

   initial begin
      rst = 1'b1; start_i = 0; len_i = 0; base_i = 0; gap_i = 0; ready_i = 0;
      tick(); tick();
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_cnt", beat_cnt_o, 0);
      rst = 1'b0;
      tick();

      // Reset in the middle of a burst.
      start_i = 1; len_i = 10; base_i = 8'h20; gap_i = 0; ready_i = 1;
      tick();
      start_i = 0;
      tick(); tick();
      chk("pre_rst_valid", valid_o, 1);
      rst = 1'b1;
      #1;
      chk("async_valid", valid_o, 0);
      chk("async_busy", busy_o, 0);
      chk("async_cnt", beat_cnt_o, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_no_done", done_o, 0);
         chk("rst_hold_valid", valid_o, 0);
      end
      rst = 1'b0;
      ready_i = 0;
      tick();
      chk("post_rst_idle", busy_o, 0);
      chk("post_rst_no_done", done_o, 0);

      run_burst(3, 8'h08, 0, 100, 0);
      run_burst(2, 8'h3C, 0, 100, 2);
      run_burst(2, 8'h48, 2, 100, 0);
      run_burst(2, 8'hFF, 0, 100, 0);
      run_burst(0, 8'h55, 1, 100, 0);
      run_burst(1, 8'hA0, 15, 100, 0);

      for (int n = 0; n < 20; n++)
         run_burst($urandom_range(0, 20), 8'($urandom), $urandom_range(0, 3),
                   $urandom_range(30, 100), $urandom_range(0, 2));

      run_burst(200, 8'($urandom), 0, 50, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
